// File: rtl/dbg_probe_stepper_pkg.sv
// Shared types for the debug stepper: mode/state encodings and
// the overlay character helper.
package dbg_probe_stepper_pkg;

  localparam int CHAR_W = 5;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HOLD = 2'b11
  } dbg_mode_t;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SLOW,
    ST_STEP_WAIT,
    ST_STEP_PULSE,
    ST_HOLD
  } dbg_state_t;

  function automatic logic [CHAR_W-1:0] hex_char(
    input logic [3:0] nib
  );
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/dbg_probe_stepper_if.sv
// OSD-side control/probe bundle for the debug stepper.
// master = OSD/controller side, slave = stepper.
interface dbg_probe_stepper_if #(
  parameter int NUM_CH  = 8,
  parameter int PROBE_W = 16,
  parameter int DIV_W   = 26
);
  import dbg_probe_stepper_pkg::*;

  localparam int ROW_W = NUM_CH * (PROBE_W / 4) * CHAR_W;

  logic [1:0]                  mode;
  logic                        step_req;
  logic [DIV_W-1:0]            slow_div;
  logic                        freeze;
  logic [NUM_CH*PROBE_W-1:0]   probe_in;
  logic                        cpu_ce;
  logic [15:0]                 step_count;
  logic                        snap_valid;
  logic [ROW_W-1:0]            row_out;

  modport master (
    output mode,
    output step_req,
    output slow_div,
    output freeze,
    output probe_in,
    input  cpu_ce,
    input  step_count,
    input  snap_valid,
    input  row_out
  );

  modport slave (
    input  mode,
    input  step_req,
    input  slow_div,
    input  freeze,
    input  probe_in,
    output cpu_ce,
    output step_count,
    output snap_valid,
    output row_out
  );

endinterface

// File: rtl/dbg_probe_stepper_ce_divider.sv
// SLOW-mode period counter: loads period-1 on start or tick,
// decrements otherwise, ticks when it reaches zero.
module dbg_probe_stepper_ce_divider #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] reload;

  // a period of 0 behaves like 1: tick every cycle
  assign reload = (period == '0) ? '0 : period - DIV_W'(1);
  assign tick   = active & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = reload;
    end else if (!active) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbg_probe_stepper.sv
// Debug CPU clock-enable stepper with probe snapshot and
// hex-character row formatting for the OSD overlay.
module dbg_probe_stepper #(
  parameter int NUM_CH  = 8,
  parameter int PROBE_W = 16,
  parameter int DIV_W   = 26
) (
  input logic                clk_sys,
  input logic                reset_n,
  dbg_probe_stepper_if.slave dbg
);
  import dbg_probe_stepper_pkg::*;

  localparam int NIB   = PROBE_W / 4;
  localparam int PRB_W = NUM_CH * PROBE_W;
  localparam int OUT_W = NUM_CH * NIB * CHAR_W;

  dbg_state_t       state_q;
  dbg_state_t       state_d;
  dbg_mode_t        mode;
  logic             step_prev_q;
  logic             cap_pend_q;
  logic             cap_pend_d;
  logic             snap_valid_q;
  logic             snap_valid_d;
  logic [15:0]      step_count_q;
  logic [15:0]      step_count_d;
  logic [PRB_W-1:0] snap_q;
  logic [PRB_W-1:0] snap_d;
  logic [OUT_W-1:0] row_q;
  logic [OUT_W-1:0] row_d;
  logic             step_edge;
  logic             slow_act;
  logic             slow_start;
  logic             div_tick;
  logic             cpu_ce;
  logic             latch_en;
  logic             cnt_inc;

  assign mode       = dbg_mode_t'(dbg.mode);
  assign step_edge  = dbg.step_req & ~step_prev_q;
  assign slow_act   = (state_q == ST_SLOW);
  assign slow_start = (state_d == ST_SLOW) & ~slow_act;

  always_comb begin
    state_d = ST_HOLD;
    unique case (mode)
      MODE_RUN:  state_d = ST_RUN;
      MODE_SLOW: state_d = ST_SLOW;
      // edges seen while pulsing are dropped, not queued
      MODE_STEP: begin
        if (state_q == ST_STEP_WAIT && step_edge) begin
          state_d = ST_STEP_PULSE;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      MODE_HOLD: state_d = ST_HOLD;
      default:   state_d = ST_HOLD;
    endcase
  end

  dbg_probe_stepper_ce_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk_sys),
    .rst_n  (reset_n),
    .start  (slow_start),
    .active (slow_act),
    .period (dbg.slow_div),
    .tick   (div_tick)
  );

  always_comb begin
    cpu_ce = 1'b0;
    unique case (state_q)
      ST_RUN:        cpu_ce = 1'b1;
      ST_SLOW:       cpu_ce = div_tick;
      ST_STEP_PULSE: cpu_ce = 1'b1;
      default:       cpu_ce = 1'b0;
    endcase
  end

  // latch one edge after the CPU's enabled edge so probes have settled
  assign cnt_inc  = cpu_ce & (slow_act | (state_q == ST_STEP_PULSE));
  assign latch_en = ~dbg.freeze & (cap_pend_q | (state_q == ST_RUN));

  always_comb begin
    cap_pend_d   = cpu_ce & (state_q != ST_RUN);
    snap_d       = latch_en ? dbg.probe_in : snap_q;
    snap_valid_d = snap_valid_q | latch_en;
    step_count_d = step_count_q + {15'd0, cnt_inc};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    for (genvar i = 0; i < NIB; i++) begin : g_nib
      assign row_d[(k*NIB+i)*CHAR_W +: CHAR_W] =
        hex_char(snap_q[k*PROBE_W + i*4 +: 4]);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= ST_HOLD;
      step_prev_q  <= 1'b1;
      cap_pend_q   <= 1'b0;
      snap_valid_q <= 1'b0;
      step_count_q <= '0;
      snap_q       <= '0;
      row_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_prev_q  <= dbg.step_req;
      cap_pend_q   <= cap_pend_d;
      snap_valid_q <= snap_valid_d;
      step_count_q <= step_count_d;
      snap_q       <= snap_d;
      row_q        <= row_d;
    end
  end

  assign dbg.cpu_ce     = cpu_ce;
  assign dbg.step_count = step_count_q;
  assign dbg.snap_valid = snap_valid_q;
  assign dbg.row_out    = row_q;

endmodule

// File: tb/tb_dbg_probe_stepper.sv
// Self-checking bench for dbg_probe_stepper: reset, step, slow,
// freeze, mode switching and step counter wrap.
module tb_dbg_probe_stepper;
  import dbg_probe_stepper_pkg::*;

  localparam int NUM_CH  = 8;
  localparam int PROBE_W = 16;
  localparam int DIV_W   = 26;
  localparam int NIB     = PROBE_W / 4;
  localparam int PRB_W   = NUM_CH * PROBE_W;
  localparam int OUT_W   = NUM_CH * NIB * CHAR_W;

  logic clk_sys = 1'b0;
  logic reset_n;

  always #5 clk_sys = ~clk_sys;

  dbg_probe_stepper_if #(
    .NUM_CH  (NUM_CH),
    .PROBE_W (PROBE_W),
    .DIV_W   (DIV_W)
  ) dbg ();

  dbg_probe_stepper #(
    .NUM_CH  (NUM_CH),
    .PROBE_W (PROBE_W),
    .DIV_W   (DIV_W)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .dbg     (dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [OUT_W-1:0] sb_row[$];
  logic             sb_ce[$];

  function automatic logic [OUT_W-1:0] fmt(
    input logic [PRB_W-1:0] p
  );
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH*NIB; k++) begin
      r[k*CHAR_W +: CHAR_W] = {1'b0, p[k*4 +: 4]};
    end
    return r;
  endfunction

  function automatic logic [PRB_W-1:0] rnd_probe();
    logic [PRB_W-1:0] r;
    r = '0;
    for (int i = 0; i < PRB_W/32; i++) begin
      r[i*32 +: 32] = $urandom;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n      = 1'b0;
    dbg.mode     = 2'b11;
    dbg.step_req = 1'b1;
    dbg.freeze   = 1'b0;
    dbg.slow_div = '0;
    dbg.probe_in = '0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int pulses;
    @(negedge clk_sys);
    reset_n      = 1'b0;
    dbg.mode     = 2'b00;
    dbg.step_req = 1'b1;
    dbg.probe_in = rnd_probe();
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (dbg.cpu_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cpu_ce: got %0b expected 0", dbg.cpu_ce);
    end
    n_checks++;
    if (dbg.step_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_step_count: got %h expected 0000", dbg.step_count);
    end
    n_checks++;
    if (dbg.snap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_snap_valid: got %0b expected 0", dbg.snap_valid);
    end
    n_checks++;
    if (dbg.row_out !== '0) begin
      n_fail++;
      $display("FAIL reset_row_out: got %h expected 0", dbg.row_out);
    end
    reset_n  = 1'b1;
    dbg.mode = 2'b10;
    pulses   = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (dbg.cpu_ce === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_no_step: got %0d pulses expected 0", pulses);
    end
    n_checks++;
    if (dbg.step_count !== 16'd0 || dbg.snap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_state: got cnt=%h sv=%0b expected 0000/0",
               dbg.step_count, dbg.snap_valid);
    end
  endtask

  task automatic test_step();
    int pulses;
    int run;
    int max_run;
    int since;
    logic [PRB_W-1:0] p;
    logic [OUT_W-1:0] exp_row;
    logic [19:0] row0_exp;
    row0_exp = {5'h0A, 5'h05, 5'h0C, 5'h03};
    pulses = 0;
    run = 0;
    max_run = 0;
    since = -1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk_sys);
      p = rnd_probe();
      if (s == 0) p[15:0] = 16'hA5C3;
      dbg.probe_in = p;
      dbg.step_req = 1'b0;
      @(negedge clk_sys);
      dbg.step_req = 1'b1;
      sb_row.push_back(fmt(p));
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_sys);
        if (dbg.cpu_ce === 1'b1) begin
          pulses++;
          run++;
          if (run > max_run) max_run = run;
          since = 0;
        end else begin
          run = 0;
          if (since >= 0) begin
            since++;
            if (since == 3) begin
              since = -1;
              n_checks++;
              if (sb_row.size() == 0) begin
                n_fail++;
                $display("FAIL step_row_sb: got output with empty queue expected none");
              end else begin
                exp_row = sb_row.pop_front();
                if (dbg.row_out !== exp_row) begin
                  n_fail++;
                  $display("FAIL step_row: got %h expected %h", dbg.row_out, exp_row);
                end
              end
            end
          end
        end
      end
      if (s == 0) begin
        n_checks++;
        if (pulses !== 1) begin
          n_fail++;
          $display("FAIL step_single_pulse: got %0d expected 1", pulses);
        end
        n_checks++;
        if (dbg.step_count !== 16'd1) begin
          n_fail++;
          $display("FAIL step_count_1: got %h expected 0001", dbg.step_count);
        end
        n_checks++;
        if (dbg.snap_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL step_snap_valid: got %0b expected 1", dbg.snap_valid);
        end
        n_checks++;
        if (dbg.row_out[19:0] !== row0_exp) begin
          n_fail++;
          $display("FAIL step_row0_chars: got %h expected %h",
                   dbg.row_out[19:0], row0_exp);
        end
      end
    end
    n_checks++;
    if (pulses !== 4 || max_run !== 1) begin
      n_fail++;
      $display("FAIL step_pulses: got %0d (max len %0d) expected 4 (max len 1)",
               pulses, max_run);
    end
    n_checks++;
    if (dbg.step_count !== 16'd4) begin
      n_fail++;
      $display("FAIL step_count_4: got %h expected 0004", dbg.step_count);
    end
    n_checks++;
    if (sb_row.size() !== 0) begin
      n_fail++;
      $display("FAIL step_sb_drain: got %0d left expected 0", sb_row.size());
    end
  endtask

  task automatic test_slow();
    int pulses;
    logic exp_ce;
    do_reset();
    @(negedge clk_sys);
    dbg.mode     = 2'b01;
    dbg.slow_div = DIV_W'(4);
    for (int i = 0; i < 72; i++) begin
      if (i < 40)      sb_ce.push_back((i % 4) == 3);
      else if (i < 48) sb_ce.push_back(1'b1);
      else             sb_ce.push_back((i-48) == 3 || (i-48) == 7 ||
                                       (i-48) == 14 || (i-48) == 21);
    end
    pulses = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk_sys);
      exp_ce = sb_ce.pop_front();
      n_checks++;
      if (dbg.cpu_ce !== exp_ce) begin
        n_fail++;
        $display("FAIL slow_ce cycle %0d: got %0b expected %0b",
                 i, dbg.cpu_ce, exp_ce);
      end
      if (i < 40 && dbg.cpu_ce === 1'b1) pulses++;
      if (i == 39) begin
        n_checks++;
        if (pulses !== 10) begin
          n_fail++;
          $display("FAIL slow_pulse_count: got %0d expected 10", pulses);
        end
        n_checks++;
        if (dbg.step_count !== 16'd9) begin
          n_fail++;
          $display("FAIL slow_step_count: got %h expected 0009", dbg.step_count);
        end
        dbg.slow_div = '0;
      end
      if (i == 47) dbg.slow_div = DIV_W'(4);
      if (i == 53) dbg.slow_div = DIV_W'(7);
    end
  endtask

  task automatic test_freeze();
    logic [PRB_W-1:0] p;
    logic [PRB_W-1:0] exp_snap;
    logic [OUT_W-1:0] exp_row;
    do_reset();
    @(negedge clk_sys);
    dbg.mode = 2'b00;
    exp_snap = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_sys);
      if (n >= 2) begin
        exp_row = sb_row.pop_front();
        n_checks++;
        if (dbg.row_out !== exp_row) begin
          n_fail++;
          $display("FAIL freeze_row n=%0d: got %h expected %h",
                   n, dbg.row_out, exp_row);
        end
      end
      n_checks++;
      if (dbg.cpu_ce !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_cpu_ce n=%0d: got %0b expected 1", n, dbg.cpu_ce);
      end
      if (n <= 17) begin
        p = rnd_probe();
        dbg.probe_in = p;
        dbg.freeze   = (n >= 4 && n <= 11);
        if (!dbg.freeze) exp_snap = p;
        sb_row.push_back(fmt(exp_snap));
      end
    end
    dbg.freeze = 1'b0;
    n_checks++;
    if (dbg.snap_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_snap_valid: got %0b expected 1", dbg.snap_valid);
    end
  endtask

  task automatic test_mode_switch();
    int pulses;
    logic exp_ce;
    logic [PRB_W-1:0] pa;
    logic [PRB_W-1:0] pc;
    logic [PRB_W-1:0] pd;
    do_reset();
    @(negedge clk_sys);
    pa           = rnd_probe();
    dbg.probe_in = pa;
    dbg.mode     = 2'b10;
    dbg.step_req = 1'b0;
    @(negedge clk_sys);
    dbg.step_req = 1'b1;
    @(negedge clk_sys);
    n_checks++;
    if (dbg.cpu_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL switch_step_pulse: got %0b expected 1", dbg.cpu_ce);
    end
    dbg.mode = 2'b11;
    pulses = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (dbg.cpu_ce === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL switch_hold_extra: got %0d extra ce cycles expected 0", pulses);
    end
    n_checks++;
    if (dbg.step_count !== 16'd1 || dbg.snap_valid !== 1'b1 ||
        dbg.row_out !== fmt(pa)) begin
      n_fail++;
      $display("FAIL switch_step_capture: got cnt=%h sv=%0b row=%h expected 0001/1/%h",
               dbg.step_count, dbg.snap_valid, dbg.row_out, fmt(pa));
    end
    dbg.probe_in = rnd_probe();
    repeat (4) @(negedge clk_sys);
    n_checks++;
    if (dbg.row_out !== fmt(pa)) begin
      n_fail++;
      $display("FAIL switch_hold_no_capture: got %h expected %h",
               dbg.row_out, fmt(pa));
    end
    pc           = rnd_probe();
    dbg.probe_in = pc;
    dbg.mode     = 2'b00;
    repeat (4) @(negedge clk_sys);
    dbg.mode     = 2'b01;
    dbg.slow_div = DIV_W'(5);
    for (int j = 0; j < 12; j++) sb_ce.push_back((j % 5) == 4);
    pd = rnd_probe();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk_sys);
      exp_ce = sb_ce.pop_front();
      n_checks++;
      if (dbg.cpu_ce !== exp_ce) begin
        n_fail++;
        $display("FAIL run_to_slow_ce j=%0d: got %0b expected %0b",
                 j, dbg.cpu_ce, exp_ce);
      end
      if (j == 0) dbg.probe_in = pd;
      if (j == 3) begin
        n_checks++;
        if (dbg.row_out !== fmt(pc)) begin
          n_fail++;
          $display("FAIL slow_entry_no_capture: got %h expected %h",
                   dbg.row_out, fmt(pc));
        end
      end
    end
    n_checks++;
    if (dbg.row_out !== fmt(pd)) begin
      n_fail++;
      $display("FAIL slow_capture: got %h expected %h", dbg.row_out, fmt(pd));
    end
    n_checks++;
    if (dbg.step_count !== 16'd3) begin
      n_fail++;
      $display("FAIL switch_step_count: got %h expected 0003", dbg.step_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk_sys);
    dbg.mode     = 2'b01;
    dbg.slow_div = '0;
    repeat (65535) @(negedge clk_sys);
    dbg.mode     = 2'b10;
    dbg.step_req = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (dbg.step_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h expected ffff", dbg.step_count);
    end
    dbg.step_req = 1'b1;
    @(negedge clk_sys);
    n_checks++;
    if (dbg.cpu_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse: got %0b expected 1", dbg.cpu_ce);
    end
    @(negedge clk_sys);
    n_checks++;
    if (dbg.step_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h expected 0000", dbg.step_count);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    dbg.mode     = 2'b11;
    dbg.step_req = 1'b1;
    dbg.slow_div = '0;
    dbg.freeze   = 1'b0;
    dbg.probe_in = '0;
    test_reset();
    test_step();
    test_slow();
    test_freeze();
    test_mode_switch();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
